// File: rtl/cut_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// cut_sweep_ctrl_if
// Truth-table row stream between the sweep controller and the collector.
//   tt_valid : row valid (controller -> collector)
//   tt_ready : collector ready (collector -> controller)
//   tt_addr  : input vector of the current row
//   tt_data  : captured CUT response, f1 at bit 0
// Modports: master = controller side, slave = collector side.
// ---------------------------------------------------------------------------
interface cut_sweep_ctrl_if #(
  parameter int N_IN  = 5,
  parameter int N_OUT = 13
);
  logic             tt_valid;
  logic             tt_ready;
  logic [N_IN-1:0]  tt_addr;
  logic [N_OUT-1:0] tt_data;

  modport master (output tt_valid, output tt_addr, output tt_data, input tt_ready);
  modport slave  (input tt_valid, input tt_addr, input tt_data, output tt_ready);
endinterface

// File: rtl/cut_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// cut_sweep_ctrl
// Walks a combinational circuit-under-test through all 2^N_IN input vectors.
// Each vector is applied, left to settle for SETTLE cycles, then the CUT
// response is captured and offered as one truth-table row on the tt stream.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : begin a sweep (honoured only while idle)
//   abort      : cancel a sweep in progress at the next edge
//   x_out      : vector driven to the CUT inputs
//   f_in       : CUT outputs, f1 at bit 0
//   busy       : high from the start-accept edge until back in IDLE
//   done       : one-cycle pulse after the last row is accepted
//   sig        : MISR signature over all accepted rows
//   tt         : truth-table row stream (master side)
//
// Build option: define CUT_SWEEP_MISR_EN to include the signature register;
// without it sig is tied to zero.
// ---------------------------------------------------------------------------
module cut_sweep_ctrl #(
  parameter int               N_IN   = 5,
  parameter int               N_OUT  = 13,
  parameter int               SETTLE = 2,
  parameter logic [N_OUT-1:0] POLY   = 13'h001B
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   x_out,
  input  logic [N_OUT-1:0]  f_in,
  output logic              busy,
  output logic              done,
  output logic [N_OUT-1:0]  sig,
  cut_sweep_ctrl_if.master  tt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_APPLY   = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST_IDX   = {N_IN{1'b1}};

  // One MISR step: shift left, fold the carried-out bit back through POLY,
  // then absorb the new response word.
  function automatic logic [N_OUT-1:0] misr_next(input logic [N_OUT-1:0] cur,
                                                 input logic [N_OUT-1:0] din);
    logic [N_OUT-1:0] fb;
    fb = cur[N_OUT-1] ? POLY : {N_OUT{1'b0}};
    return {cur[N_OUT-2:0], 1'b0} ^ fb ^ din;
  endfunction

  logic [2:0]       state_r;
  logic [3:0]       cnt_r;
  logic [N_IN-1:0]  idx_r;
  logic             busy_r;
  logic             done_r;
  logic             tt_valid_r;
  logic [N_IN-1:0]  tt_addr_r;
  logic [N_OUT-1:0] tt_data_r;
  logic             start_s;
  logic             accept_s;

  // abort beats start in IDLE and beats the handshake in CAPTURE
  assign start_s  = (state_r == S_IDLE) && start && !abort;
  assign accept_s = (state_r == S_CAPTURE) && tt_valid_r && tt.tt_ready && !abort;

  // Sweep sequencer: state, vector index, settle counter and row registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      cnt_r      <= 4'd0;
      idx_r      <= {N_IN{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      tt_valid_r <= 1'b0;
      tt_addr_r  <= {N_IN{1'b0}};
      tt_data_r  <= {N_OUT{1'b0}};
    end else if (abort && (state_r != S_IDLE)) begin
      // cancel: rows and x_out keep their last values, no done pulse
      state_r    <= S_IDLE;
      cnt_r      <= 4'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      tt_valid_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            state_r <= S_APPLY;
            idx_r   <= {N_IN{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_APPLY: begin
          cnt_r   <= SETTLE_CNT;
          state_r <= S_SETTLE;
        end
        S_SETTLE: begin
          // counter was loaded with SETTLE, so this fires after SETTLE cycles
          if (cnt_r <= 4'd1) begin
            cnt_r      <= 4'd0;
            tt_data_r  <= f_in;
            tt_addr_r  <= idx_r;
            tt_valid_r <= 1'b1;
            state_r    <= S_CAPTURE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_CAPTURE: begin
          if (accept_s) begin
            tt_valid_r <= 1'b0;
            if (idx_r == LAST_IDX) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end else begin
              // x_out moves to the next vector on entry to APPLY, never mid-row
              idx_r   <= idx_r + 1'b1;
              state_r <= S_APPLY;
            end
          end else begin
            state_r <= S_CAPTURE;
          end
        end
        S_DONE: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r    <= S_IDLE;
          busy_r     <= 1'b0;
          tt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign x_out       = idx_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign tt.tt_valid = tt_valid_r;
  assign tt.tt_addr  = tt_addr_r;
  assign tt.tt_data  = tt_data_r;

`ifdef CUT_SWEEP_MISR_EN
  logic [N_OUT-1:0] sig_r;

  // Signature register: cleared on start, folds in each accepted row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_r <= {N_OUT{1'b0}};
    end else if (start_s) begin
      sig_r <= {N_OUT{1'b0}};
    end else if (accept_s) begin
      sig_r <= misr_next(sig_r, tt_data_r);
    end else begin
      sig_r <= sig_r;
    end
  end

  assign sig = sig_r;
`else
  assign sig = {N_OUT{1'b0}};
`endif

endmodule

// File: tb/tb_cut_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cut_sweep_ctrl
// Self-checking bench for cut_sweep_ctrl with default parameters. A small
// CUT model (selected by f_mode) feeds f_in from x_out; expected rows and the
// expected signature are computed from that model with plain arithmetic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cut_sweep_ctrl;

  localparam int N_IN   = 5;
  localparam int N_OUT  = 13;
  localparam int SETTLE = 2;
  localparam int NVEC   = 1 << N_IN;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [N_IN-1:0]   x_out;
  logic [N_OUT-1:0]  f_in;
  logic              busy;
  logic              done;
  logic [N_OUT-1:0]  sig;

  cut_sweep_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) tt_bus ();

  cut_sweep_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .x_out (x_out),
    .f_in  (f_in),
    .busy  (busy),
    .done  (done),
    .sig   (sig),
    .tt    (tt_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // CUT model: 0 loopback, 1 random table, 2 all zero, 3 one-hot on vector 0
  int              f_mode;
  logic [N_OUT-1:0] rand_tab [NVEC];

  always_comb begin
    f_in = '0;
    case (f_mode)
      0: f_in = {{(N_OUT-N_IN){1'b0}}, x_out};
      1: f_in = rand_tab[x_out];
      2: f_in = '0;
      3: f_in = (x_out == '0) ? 13'd1 : 13'd0;
      default: f_in = '0;
    endcase
  end

  function automatic int exp_row(input int k);
    if (k < 0 || k >= NVEC) return 0;
    case (f_mode)
      0: return k;
      1: return int'(rand_tab[k]);
      3: return (k == 0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Signature after the first n rows, from the shift/fold rule
  function automatic int misr_ref(input int n);
    int s = 0;
    int c;
    for (int k = 0; k < n; k++) begin
      c = (s >> 12) & 1;
      s = ((s << 1) & 32'h1FFF) ^ ((c != 0) ? 32'h001B : 32'h0) ^ exp_row(k);
    end
    return s;
  endfunction

  function automatic int exp_sig(input int n);
`ifdef CUT_SWEEP_MISR_EN
    return misr_ref(n);
`else
    return (n < 0) ? 1 : 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Full sweep from IDLE; caller is at a negedge. Returns at a negedge.
  task automatic sweep(input int stall_k, input int stall_len, input bit rnd,
                       input int exp_first, input int exp_done);
    int e = 0;
    int rows = 0;
    int dones = 0;
    int first = -1;
    int done_e = -1;
    int stall_left = stall_len;
    bit fin = 1'b0;
    bit held = 1'b0;
    logic [N_IN-1:0]  h_addr = '0;
    logic [N_OUT-1:0] h_data = '0;
    start = 1'b1;
    tt_bus.tt_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (held) begin
        chk("hold_valid", 32'(tt_bus.tt_valid), 32'd1);
        chk("hold_addr", 32'(tt_bus.tt_addr), 32'(h_addr));
        chk("hold_data", 32'(tt_bus.tt_data), 32'(h_data));
        chk("hold_x_out", 32'(x_out), 32'(h_addr));
      end
      if (tt_bus.tt_valid && first < 0) first = e;
      if (done) begin
        dones++;
        done_e = e;
      end else if (dones > 0) begin
        chk("busy_after_done", 32'(busy), 32'd0);
        fin = 1'b1;
        break;
      end
      if (tt_bus.tt_valid && (int'(tt_bus.tt_addr) == stall_k) && stall_left > 0) begin
        tt_bus.tt_ready = 1'b0;
        stall_left--;
      end else begin
        tt_bus.tt_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      held = tt_bus.tt_valid && !tt_bus.tt_ready;
      if (tt_bus.tt_valid && tt_bus.tt_ready) begin
        chk("row_addr", 32'(tt_bus.tt_addr), 32'(rows));
        chk("row_data", 32'(tt_bus.tt_data), 32'(exp_row(rows)));
        rows++;
      end
      h_addr = tt_bus.tt_addr;
      h_data = tt_bus.tt_data;
      @(negedge clk);
      e++;
    end
    tt_bus.tt_ready = 1'b1;
    chk("sweep_finished", 32'(fin), 32'd1);
    chk("row_count", 32'(rows), 32'(NVEC));
    chk("done_count", 32'(dones), 32'd1);
    if (exp_first >= 0) chk("first_valid_edge", 32'(first), 32'(exp_first));
    // done appears in the cycle after the final handshake edge
    if (exp_done >= 0) chk("done_edge", 32'(done_e), 32'(exp_done));
    chk("sig_at_done", 32'(sig), 32'(exp_sig(NVEC)));
  endtask

  typedef struct {
    logic            start;
    logic            abort;
    logic            ready;
    logic            exp_busy;
    logic            exp_valid;
    logic            exp_done;
    logic            chk_x;
    logic [N_IN-1:0] exp_x;
    logic [N_IN-1:0] exp_addr;
  } vec_t;

  vec_t tbl [11];

  initial begin
    bit found;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tt_bus.tt_ready = 1'b0;
    f_mode = 0;
    for (int k = 0; k < NVEC; k++) rand_tab[k] = 13'($urandom);

    // start abort ready | busy valid done chk_x x addr  (state after the edge)
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0}; // idle
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0}; // APPLY
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0}; // SETTLE
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0}; // start ignored
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0}; // row 0 valid
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0}; // stalled
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd0}; // accepted
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd0}; // SETTLE
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0}; // abort
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0}; // abort wins
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0}; // stays idle

    #23;
    chk("rst_x_out", 32'(x_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(tt_bus.tt_valid), 32'd0);
    chk("rst_addr", 32'(tt_bus.tt_addr), 32'd0);
    chk("rst_data", 32'(tt_bus.tt_data), 32'd0);
    chk("rst_sig", 32'(sig), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single-step timeline vectors
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].start;
      abort = tbl[i].abort;
      tt_bus.tt_ready = tbl[i].ready;
      @(negedge clk);
      chk("tbl_busy", 32'(busy), 32'(tbl[i].exp_busy));
      chk("tbl_valid", 32'(tt_bus.tt_valid), 32'(tbl[i].exp_valid));
      chk("tbl_done", 32'(done), 32'(tbl[i].exp_done));
      if (tbl[i].chk_x) begin
        chk("tbl_x_out", 32'(x_out), 32'(tbl[i].exp_x));
        chk("tbl_addr", 32'(tt_bus.tt_addr), 32'(tbl[i].exp_addr));
      end
    end
    start = 1'b0;
    abort = 1'b0;

    // loopback, ready always high: timing and row order
    f_mode = 0;
    sweep(-1, 0, 1'b0, SETTLE + 1, (SETTLE + 2) * NVEC);

    // backpressure on vector 7 for 5 cycles
    sweep(7, 5, 1'b0, SETTLE + 1, -1);

    // random CUT responses with random ready
    f_mode = 1;
    sweep(-1, 0, 1'b1, -1, -1);

    // abort while settling vector 10
    f_mode = 0;
    start = 1'b1;
    tt_bus.tt_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (x_out == 5'd10 && !tt_bus.tt_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reach_k10", 32'(found), 32'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(tt_bus.tt_valid), 32'd0);
    chk("abort_sig_kept", 32'(sig), 32'(exp_sig(10)));
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    sweep(-1, 0, 1'b0, SETTLE + 1, (SETTLE + 2) * NVEC);

    // async reset while row 3 is waiting; a start pulse mid-sweep is ignored
    start = 1'b1;
    tt_bus.tt_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (tt_bus.tt_valid && tt_bus.tt_addr == 5'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_row3", 32'(found), 32'd1);
    tt_bus.tt_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midstart_addr", 32'(tt_bus.tt_addr), 32'd3);
    chk("midstart_x_out", 32'(x_out), 32'd3);
    chk("midstart_valid", 32'(tt_bus.tt_valid), 32'd1);
    chk("midstart_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x_out", 32'(x_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_valid", 32'(tt_bus.tt_valid), 32'd0);
    chk("arst_addr", 32'(tt_bus.tt_addr), 32'd0);
    chk("arst_data", 32'(tt_bus.tt_data), 32'd0);
    chk("arst_sig", 32'(sig), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tt_bus.tt_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'd0);

    // signature cases: all-zero responses, then a single one on vector 0
    f_mode = 2;
    sweep(-1, 0, 1'b0, -1, -1);
    f_mode = 3;
    sweep(-1, 0, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
